mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access pipeline stage between execute and writeback.
- Consumes the EX result bundle: writeback flag, destination register number, ALU result, memory op, address and store data.
- Performs loads and stores against a single-port synchronous data memory with 1-cycle read latency and 32x64k organisation.
- Produces the writeback bundle for writeback, using the same v/stall handshake as every other stage.

Parameters:
- WORD, 32, data word width
- ADDR, 16, data memory word-address width
- W_RD, 5, register number width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- v_i  in  1  EX bundle valid
- stall_o  out  1  back-pressure to EX
- wb_i  in  1  instruction writes a register
- rd_num_i  in  W_RD  destination register
- rd_data_i  in  WORD  ALU result, passed through for non-loads
- mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- maddr_i  in  ADDR  memory word address
- sdata_i  in  WORD  store data
- dm_a_o  out  ADDR  data memory address
- dm_w_o  out  1  data memory write enable
- dm_d_o  out  WORD  data memory write data
- dm_q_i  in  WORD  data memory read data, valid 1 cycle after the address is presented
- v_o  out  1  WB bundle valid
- stall_i  in  1  back-pressure from WB
- wb_o  out  1  writeback enable
- rd_num_o  out  W_RD  destination register
- rd_data_o  out  WORD  result or load data

Behaviour:
- Clock and reset: clk only. rst is sampled at the clk edge; rst==0 resets synchronously.
- Reset values: v_o=0, wb_o=0, rd_num_o=0, rd_data_o=0, FSM=RUN, dm_w_o=0, stall_o=0, all pending registers 0.
- Output register is "busy" when v_o && stall_i. While busy, the output register holds all of its values.
- stall_o = (state==LOAD_WAIT) || busy. This is combinational.
- Accept: v_i && !stall_o.
- FSM has two states, RUN and LOAD_WAIT.
- RUN, accept with op none or reserved:
  - Next cycle: v_o=1, wb_o=wb_i, rd_num_o=rd_num_i, rd_data_o=rd_data_i.
  - Latency 1.
- RUN, accept with store:
  - dm_w_o=1, dm_a_o=maddr_i, dm_d_o=sdata_i in the same cycle (combinational, gated by accept).
  - Next cycle: v_o=1, wb_o forced 0, rd_num_o=rd_num_i. rd_data_o is don't-care; drive sdata_i.
- RUN, accept with load:
  - dm_a_o=maddr_i. Latch maddr_i, rd_num_i and wb_i into pending registers.
  - Go to LOAD_WAIT. v_o becomes 0 next cycle unless the output register is held busy.
- LOAD_WAIT:
  - dm_a_o = pending address, held stable so dm_q_i remains valid.
  - If not busy: load output with v_o=1, wb_o=pending wb, rd_num_o=pending rd, rd_data_o=dm_q_i, then return to RUN. Total latency 2.
  - If busy: remain in LOAD_WAIT, with no memory write and the address unchanged.
- dm_w_o=0 whenever there is no accepted store. dm_a_o is don't-care when idle; drive maddr_i.
- When not busy and nothing completes in a cycle, v_o drops to 0 next cycle.
- A store following a load: the store cannot be accepted during LOAD_WAIT (stall_o=1), so the memory port never conflicts.
- Back-to-back non-memory ops with stall_i=0 give throughput 1/cycle. Back-to-back loads give 1 per 2 cycles.
- Reset mid-load (rst=0 while in LOAD_WAIT): the pending load is dropped, the FSM goes to RUN, and v_o=0 next cycle.
- A store issued in the same cycle as rst=0 is suppressed: dm_w_o is gated by rst.

Optional Feature:
- Macro: MEM_ACCESS_PERF_EN.
- Defined:
  - Adds outputs ld_cnt_o[31:0] and st_cnt_o[31:0].
  - Each is a free-running count of accepted loads and accepted stores, incremented on the accept cycle and wrapping at 2^32.
  - Both reset to 0.
- Undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with v_i=1 and a store to addr 0x0010 -> dm_w_o stays 0; v_o, wb_o, rd_num_o, rd_data_o are 0 after reset.
- Pass-through: op none, wb=1, rd=3, data=0x12345678, stall_i=0 -> next cycle v_o=1, wb_o=1, rd_num_o=3, rd_data_o=0x12345678; stall_o stays 0.
- Store then load:
  - Store 0xDEADBEEF to 0x0100 -> dm_w_o=1 in the accept cycle; v_o=1 next cycle with wb_o=0.
  - Load from 0x0100 into rd=7 -> stall_o=1 for one cycle; v_o=1, rd_num_o=7, rd_data_o=0xDEADBEEF two cycles after accept.
- Downstream stall:
  - Stall during a pending load: stall_i=1 for 3 cycles while a load to 0x0200 is in LOAD_WAIT and v_o=1 -> output held, stall_o=1 and dm_a_o=0x0200 throughout.
  - After stall_i falls: the load result appears next cycle.
- Reset mid-load: rst=0 in the LOAD_WAIT cycle -> v_o=0, FSM=RUN, and the next op-none instruction completes with latency 1.
- MEM_ACCESS_PERF_EN:
  - 3 loads and 2 stores, one stalled by stall_i -> ld_cnt_o=3, st_cnt_o=2. Stalled presentations of the same instruction are not double-counted.
  - Preload st_cnt to 0xFFFFFFFF via force and issue 1 store -> st_cnt_o=0.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs loads/stores against a 1-cycle synchronous data memory.
// Define MEM_ACCESS_PERF_EN to add free-running accepted-load/store counters (ld_cnt_o, st_cnt_o).
module mem_access #(
    parameter int WORD = 32,
    parameter int ADDR = 16,
    parameter int W_RD = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            stall_o,
    input  logic            wb_i,
    input  logic [W_RD-1:0] rd_num_i,
    input  logic [WORD-1:0] rd_data_i,
    input  logic [1:0]      mem_op_i,
    input  logic [ADDR-1:0] maddr_i,
    input  logic [WORD-1:0] sdata_i,
    output logic [ADDR-1:0] dm_a_o,
    output logic            dm_w_o,
    output logic [WORD-1:0] dm_d_o,
    input  logic [WORD-1:0] dm_q_i,
    output logic            v_o,
    input  logic            stall_i,
    output logic            wb_o,
    output logic [W_RD-1:0] rd_num_o,
    output logic [WORD-1:0] rd_data_o
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]     ld_cnt_o,
    output logic [31:0]     st_cnt_o
`endif
);
    typedef enum logic {RUN, LOAD_WAIT} state_t;

    state_t          state_reg, state_next;
    logic            v_reg, v_next;
    logic            wb_reg, wb_next;
    logic [W_RD-1:0] rd_num_reg, rd_num_next;
    logic [WORD-1:0] rd_data_reg, rd_data_next;
    logic [ADDR-1:0] pend_addr_reg, pend_addr_next;
    logic [W_RD-1:0] pend_rd_reg, pend_rd_next;
    logic            pend_wb_reg, pend_wb_next;

    logic busy, accept, is_load, is_store;

    assign is_load  = (mem_op_i == 2'b01);
    assign is_store = (mem_op_i == 2'b10);
    assign busy     = v_reg && stall_i;
    assign stall_o  = (state_reg == LOAD_WAIT) || busy;
    assign accept   = v_i && !stall_o;

    // Address is held on the pending value during LOAD_WAIT so dm_q_i stays valid while busy.
    assign dm_a_o = (state_reg == LOAD_WAIT) ? pend_addr_reg : maddr_i;
    assign dm_w_o = accept && is_store && rst;
    assign dm_d_o = sdata_i;

    assign v_o       = v_reg;
    assign wb_o      = wb_reg;
    assign rd_num_o  = rd_num_reg;
    assign rd_data_o = rd_data_reg;

    always_comb begin
        state_next     = state_reg;
        v_next         = v_reg;
        wb_next        = wb_reg;
        rd_num_next    = rd_num_reg;
        rd_data_next   = rd_data_reg;
        pend_addr_next = pend_addr_reg;
        pend_rd_next   = pend_rd_reg;
        pend_wb_next   = pend_wb_reg;
        if (!busy) begin
            v_next = 1'b0;
            if (state_reg == LOAD_WAIT) begin
                v_next       = 1'b1;
                wb_next      = pend_wb_reg;
                rd_num_next  = pend_rd_reg;
                rd_data_next = dm_q_i;
                state_next   = RUN;
            end else if (accept) begin
                if (is_load) begin
                    pend_addr_next = maddr_i;
                    pend_rd_next   = rd_num_i;
                    pend_wb_next   = wb_i;
                    state_next     = LOAD_WAIT;
                end else begin
                    v_next       = 1'b1;
                    wb_next      = wb_i && !is_store;
                    rd_num_next  = rd_num_i;
                    rd_data_next = is_store ? sdata_i : rd_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= RUN;
            v_reg         <= 1'b0;
            wb_reg        <= 1'b0;
            rd_num_reg    <= '0;
            rd_data_reg   <= '0;
            pend_addr_reg <= '0;
            pend_rd_reg   <= '0;
            pend_wb_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            v_reg         <= v_next;
            wb_reg        <= wb_next;
            rd_num_reg    <= rd_num_next;
            rd_data_reg   <= rd_data_next;
            pend_addr_reg <= pend_addr_next;
            pend_rd_reg   <= pend_rd_next;
            pend_wb_reg   <= pend_wb_next;
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] ld_cnt_reg, st_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_cnt_reg <= '0;
            st_cnt_reg <= '0;
        end else begin
            if (accept && is_load)  ld_cnt_reg <= ld_cnt_reg + 32'd1;
            if (accept && is_store) st_cnt_reg <= st_cnt_reg + 32'd1;
        end
    end

    assign ld_cnt_o = ld_cnt_reg;
    assign st_cnt_o = st_cnt_reg;
`endif
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed table, multi-cycle corner sequences, random vs queue model.
module tb_mem_access;
    localparam int WORD = 32;
    localparam int ADDR = 16;
    localparam int W_RD = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            v_i, stall_o, wb_i, dm_w_o, v_o, stall_i, wb_o;
    logic [W_RD-1:0] rd_num_i, rd_num_o;
    logic [WORD-1:0] rd_data_i, sdata_i, dm_d_o, dm_q_i, rd_data_o;
    logic [1:0]      mem_op_i;
    logic [ADDR-1:0] maddr_i, dm_a_o;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0]     ld_cnt_o, st_cnt_o;
`endif

    mem_access dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .wb_i(wb_i),
        .rd_num_i(rd_num_i), .rd_data_i(rd_data_i), .mem_op_i(mem_op_i),
        .maddr_i(maddr_i), .sdata_i(sdata_i), .dm_a_o(dm_a_o), .dm_w_o(dm_w_o),
        .dm_d_o(dm_d_o), .dm_q_i(dm_q_i), .v_o(v_o), .stall_i(stall_i), .wb_o(wb_o),
        .rd_num_o(rd_num_o), .rd_data_o(rd_data_o)
`ifdef MEM_ACCESS_PERF_EN
        , .ld_cnt_o(ld_cnt_o), .st_cnt_o(st_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Data memory: synchronous, 1-cycle read latency.
    logic [WORD-1:0] dmem [0:(1<<ADDR)-1];
    always @(posedge clk) begin
        if (dm_w_o) dmem[dm_a_o] <= dm_d_o;
        dm_q_i <= dmem[dm_a_o];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic wb, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [15:0] addr, input logic [31:0] sdata);
        v_i = 1'b1; mem_op_i = op; wb_i = wb; rd_num_i = rd;
        rd_data_i = rdata; maddr_i = addr; sdata_i = sdata;
    endtask

    // Present an instruction and hold it until accepted (bounded).
    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [15:0] addr,
                        input logic [31:0] sdata);
        bit ok = 0;
        drive(op, 1'b1, rd, 32'h0, addr, sdata);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall_o) begin ok = 1; break; end
            step();
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout: got stalled expected accept");
        end
        step();
        v_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [15:0] addr;
        logic [31:0] sdata;
        logic        exp_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
    } wbx_t;

    vec_t vecs[8];
    wbx_t expq[$];
    logic [31:0] ref_mem [int];

    initial begin
        int lat;
        bit acc;
        wbx_t e;

        for (int a = 0; a < (1 << ADDR); a++) dmem[a] = '0;

        vecs[0] = '{2'b00, 1'b1, 5'd3,  32'h12345678, 16'h0000, 32'h0,        1'b1, 5'd3,  32'h12345678, 1};
        vecs[1] = '{2'b11, 1'b1, 5'd9,  32'hCAFEF00D, 16'h0055, 32'h99,       1'b1, 5'd9,  32'hCAFEF00D, 1};
        vecs[2] = '{2'b10, 1'b1, 5'd4,  32'h11111111, 16'h0100, 32'hDEADBEEF, 1'b0, 5'd4,  32'hDEADBEEF, 1};
        vecs[3] = '{2'b01, 1'b1, 5'd7,  32'h22222222, 16'h0100, 32'h0,        1'b1, 5'd7,  32'hDEADBEEF, 2};
        vecs[4] = '{2'b01, 1'b1, 5'd8,  32'h33333333, 16'h0010, 32'h0,        1'b1, 5'd8,  32'h00000000, 2};
        vecs[5] = '{2'b00, 1'b0, 5'd31, 32'hFFFFFFFF, 16'h0000, 32'h0,        1'b0, 5'd31, 32'hFFFFFFFF, 1};
        vecs[6] = '{2'b10, 1'b0, 5'd2,  32'h44444444, 16'hFFFF, 32'h0BADCAFE, 1'b0, 5'd2,  32'h0BADCAFE, 1};
        vecs[7] = '{2'b01, 1'b0, 5'd1,  32'h55555555, 16'hFFFF, 32'h0,        1'b0, 5'd1,  32'h0BADCAFE, 2};

        // Reset held two edges with a store presented: the store must never write.
        rst = 1'b0; stall_i = 1'b0;
        drive(2'b10, 1'b1, 5'd6, 32'h0, 16'h0010, 32'hA5A5A5A5);
        #1;
        chk("rst_dm_w_c0", {31'b0, dm_w_o}, 32'd0);
        step();
        chk("rst_dm_w_c1", {31'b0, dm_w_o}, 32'd0);
        step();
        chk("rst_v_o", {31'b0, v_o}, 32'd0);
        chk("rst_wb_o", {31'b0, wb_o}, 32'd0);
        chk("rst_rd_num_o", {27'b0, rd_num_o}, 32'd0);
        chk("rst_rd_data_o", rd_data_o, 32'd0);
        rst = 1'b1; v_i = 1'b0;
        #1;
        chk("rst_stall_o", {31'b0, stall_o}, 32'd0);
        step();

        // Table-driven single-instruction vectors.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].wb, vecs[i].rd, vecs[i].rdata, vecs[i].addr, vecs[i].sdata);
            #1;
            chk($sformatf("vec%0d_stall_o", i), {31'b0, stall_o}, 32'd0);
            chk($sformatf("vec%0d_dm_w", i), {31'b0, dm_w_o}, {31'b0, vecs[i].op == 2'b10});
            step();
            v_i = 1'b0;
            lat = 1;
            if (vecs[i].exp_lat == 2) chk($sformatf("vec%0d_wait_stall", i), {31'b0, stall_o}, 32'd1);
            while (!v_o && lat < 6) begin step(); lat++; end
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_wb", i), {31'b0, wb_o}, {31'b0, vecs[i].exp_wb});
            chk($sformatf("vec%0d_rd", i), {27'b0, rd_num_o}, {27'b0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_data", i), rd_data_o, vecs[i].exp_data);
        end

        // Downstream stall around a load to 0x0200; EX keeps presenting a second load there.
        drive(2'b10, 1'b0, 5'd0, 32'h0, 16'h0200, 32'h5A5A0200);
        step();
        drive(2'b01, 1'b1, 5'd10, 32'h0, 16'h0200, 32'h0);
        #1;
        chk("stl_accept_l1", {31'b0, stall_o}, 32'd0);
        step();
        drive(2'b01, 1'b1, 5'd11, 32'h0, 16'h0200, 32'h0);
        stall_i = 1'b1;
        #1;
        chk("stl_lw_v_o", {31'b0, v_o}, 32'd0);
        chk("stl_lw_stall_o", {31'b0, stall_o}, 32'd1);
        chk("stl_lw_dm_a", {16'b0, dm_a_o}, 32'h0200);
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stl_hold%0d_v_o", k), {31'b0, v_o}, 32'd1);
            chk($sformatf("stl_hold%0d_rd", k), {27'b0, rd_num_o}, 32'd10);
            chk($sformatf("stl_hold%0d_data", k), rd_data_o, 32'h5A5A0200);
            chk($sformatf("stl_hold%0d_stall_o", k), {31'b0, stall_o}, 32'd1);
            chk($sformatf("stl_hold%0d_dm_a", k), {16'b0, dm_a_o}, 32'h0200);
            chk($sformatf("stl_hold%0d_dm_w", k), {31'b0, dm_w_o}, 32'd0);
            step();
        end
        stall_i = 1'b0;
        #1;
        chk("stl_release_stall_o", {31'b0, stall_o}, 32'd0);
        step();
        v_i = 1'b0;
        #1;
        chk("stl_l2_wait_v_o", {31'b0, v_o}, 32'd0);
        chk("stl_l2_wait_dm_a", {16'b0, dm_a_o}, 32'h0200);
        step();
        chk("stl_l2_v_o", {31'b0, v_o}, 32'd1);
        chk("stl_l2_rd", {27'b0, rd_num_o}, 32'd11);
        chk("stl_l2_data", rd_data_o, 32'h5A5A0200);

        // Reset while in LOAD_WAIT drops the load; next op-none has latency 1.
        drive(2'b01, 1'b1, 5'd12, 32'h0, 16'h0100, 32'h0);
        step();
        v_i = 1'b0; rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_v_o", {31'b0, v_o}, 32'd0);
        chk("mid_rst_stall_o", {31'b0, stall_o}, 32'd0);
        drive(2'b00, 1'b1, 5'd13, 32'h00000077, 16'h0, 32'h0);
        step();
        v_i = 1'b0;
        chk("mid_rst_op_v_o", {31'b0, v_o}, 32'd1);
        chk("mid_rst_op_rd", {27'b0, rd_num_o}, 32'd13);
        chk("mid_rst_op_data", rd_data_o, 32'h00000077);
        step();
        chk("mid_rst_no_stray", {31'b0, v_o}, 32'd0);

        // Random traffic against an in-order transaction model.
        for (int c = 0; c < 400; c++) begin
            v_i = 1'($urandom_range(0, 1));
            mem_op_i = 2'($urandom);
            wb_i = 1'($urandom);
            rd_num_i = 5'($urandom);
            rd_data_i = $urandom;
            maddr_i = 16'h0400 + 16'($urandom_range(0, 15));
            sdata_i = $urandom;
            stall_i = ($urandom_range(0, 3) == 0);
            #1;
            acc = v_i && !stall_o;
            if (dm_w_o !== (acc && mem_op_i == 2'b10)) chk("rand_dm_w", {31'b0, dm_w_o}, {31'b0, acc && mem_op_i == 2'b10});
            if (v_o && !stall_i) begin
                if (expq.size() == 0) begin
                    chk("rand_unexpected_v_o", {31'b0, v_o}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rand_wb", {31'b0, wb_o}, {31'b0, e.wb});
                    chk("rand_rd", {27'b0, rd_num_o}, {27'b0, e.rd});
                    chk("rand_data", rd_data_o, e.data);
                end
            end
            if (acc) begin
                e.wb = (mem_op_i == 2'b10) ? 1'b0 : wb_i;
                e.rd = rd_num_i;
                if (mem_op_i == 2'b01)
                    e.data = ref_mem.exists(int'(maddr_i)) ? ref_mem[int'(maddr_i)] : 32'h0;
                else if (mem_op_i == 2'b10)
                    e.data = sdata_i;
                else
                    e.data = rd_data_i;
                expq.push_back(e);
                if (mem_op_i == 2'b10) ref_mem[int'(maddr_i)] = sdata_i;
            end
            step();
        end
        v_i = 1'b0; stall_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (v_o && expq.size() != 0) begin
                e = expq.pop_front();
                chk("drain_wb", {31'b0, wb_o}, {31'b0, e.wb});
                chk("drain_rd", {27'b0, rd_num_o}, {27'b0, e.rd});
                chk("drain_data", rd_data_o, e.data);
            end
            step();
        end
        chk("rand_queue_empty", expq.size(), 32'd0);

`ifdef MEM_ACCESS_PERF_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("perf_rst_ld", ld_cnt_o, 32'd0);
        chk("perf_rst_st", st_cnt_o, 32'd0);
        send(2'b01, 5'd1, 16'h0100, 32'h0);
        send(2'b10, 5'd2, 16'h0300, 32'h13579BDF);
        send(2'b01, 5'd3, 16'h0300, 32'h0);
        send(2'b00, 5'd4, 16'h0000, 32'h0);
        stall_i = 1'b1;
        drive(2'b10, 1'b1, 5'd5, 32'h0, 16'h0301, 32'h2468ACE0);
        #1;
        chk("perf_stalled_stall_o", {31'b0, stall_o}, 32'd1);
        step();
        step();
        chk("perf_stalled_st_cnt", st_cnt_o, 32'd1);
        stall_i = 1'b0;
        send(2'b10, 5'd5, 16'h0301, 32'h2468ACE0);
        send(2'b01, 5'd6, 16'h0301, 32'h0);
        step();
        step();
        chk("perf_ld_cnt", ld_cnt_o, 32'd3);
        chk("perf_st_cnt", st_cnt_o, 32'd2);
        force dut.st_cnt_reg = 32'hFFFFFFFF;
        #1;
        release dut.st_cnt_reg;
        send(2'b10, 5'd7, 16'h0302, 32'h1);
        chk("perf_st_wrap", st_cnt_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
